// File: rtl/load_store_unit_if.sv
// Purpose: bundles the load/store request/response handshake and the data-RAM
//          port of the load/store unit into a single interface.
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request from execute stage
//   resp_valid/resp_rdata/resp_err                           : completion back to pipeline
//   mem_read/mem_write/mem_size/mem_addr/mem_wdata           : commands to the data RAM
//   mem_rdata                                                : RAM read data (one cycle after mem_read)
// Modports:
//   slave  : the load/store unit's view
//   master : the environment's view (pipeline + RAM)
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_size, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_size, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Purpose: CPU-side initiator for the data RAM. Accepts one load/store per
//          handshake, issues aligned word reads (lane extraction and sign/zero
//          extension done locally), issues byte/word writes and splits halfword
//          stores into two byte writes. Misaligned, out-of-range and illegal
//          requests complete with resp_err and never touch the RAM.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : load_store_unit_if.slave (request, response and RAM signals)
module load_store_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = 8001
) (
    input  logic             clk,
    input  logic             resetn,
    load_store_unit_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_CAP   = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_WR_LO = 3'd4;
    localparam logic [2:0] ST_WR_HI = 3'd5;
    localparam logic [2:0] ST_RESP  = 3'd6;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic [ADDR_W-3:0] LP_MEM_WORDS = (ADDR_W-2)'(MEM_WORDS);

    // State and captured request
    logic [2:0]        r_state,  w_state;
    logic [2:0]        r_funct3, w_funct3;
    logic [ADDR_W-1:0] r_addr,   w_addr;
    logic [31:0]       r_wdata,  w_wdata;

    // Registered outputs
    logic              r_resp_valid, w_resp_valid;
    logic [31:0]       r_resp_rdata, w_resp_rdata;
    logic              r_resp_err,   w_resp_err;
    logic              r_mem_read,   w_mem_read;
    logic              r_mem_write,  w_mem_write;
    logic [2:0]        r_mem_size,   w_mem_size;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr;
    logic [31:0]       r_mem_wdata,  w_mem_wdata;

    logic        w_accept;
    logic        w_f3_bad;
    logic        w_misalign;
    logic        w_out_of_range;
    logic        w_req_err;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);

    // Request legality, evaluated on the live request at accept time.
    always_comb begin
        w_f3_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                   (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
        w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        w_out_of_range = bus.req_addr[ADDR_W-1:2] >= LP_MEM_WORDS;
        w_req_err = w_f3_bad || w_misalign || w_out_of_range;
    end

    // Lane extraction from the word returned by the RAM during CAP.
    always_comb begin
        unique case (r_addr[1:0])
            2'b00:   w_lane_byte = bus.mem_rdata[7:0];
            2'b01:   w_lane_byte = bus.mem_rdata[15:8];
            2'b10:   w_lane_byte = bus.mem_rdata[23:16];
            default: w_lane_byte = bus.mem_rdata[31:24];
        endcase
        w_lane_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        unique case (r_funct3)
            3'b000:  w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'b100:  w_load_data = {24'b0, w_lane_byte};
            3'b001:  w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
            3'b101:  w_load_data = {16'b0, w_lane_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state      = r_state;
        w_funct3     = r_funct3;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_resp_valid = r_resp_valid;
        w_resp_rdata = r_resp_rdata;
        w_resp_err   = r_resp_err;
        w_mem_read   = r_mem_read;
        w_mem_write  = r_mem_write;
        w_mem_size   = r_mem_size;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_funct3 = bus.req_funct3;
                    w_addr   = bus.req_addr;
                    w_wdata  = bus.req_wdata;
                    if (w_req_err) begin
                        w_state      = ST_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_err   = 1'b1;
                        w_resp_rdata = 32'h0;
                    end else if (!bus.req_we) begin
                        w_state    = ST_RD;
                        w_mem_read = 1'b1;
                        w_mem_size = SIZE_WORD;
                        w_mem_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end else if (bus.req_funct3[1:0] == 2'b01) begin
                        // Halfword store: low byte first, high byte next cycle.
                        w_state     = ST_WR_LO;
                        w_mem_write = 1'b1;
                        w_mem_size  = SIZE_BYTE;
                        w_mem_addr  = bus.req_addr;
                        w_mem_wdata = {24'b0, bus.req_wdata[7:0]};
                    end else begin
                        w_state     = ST_WR;
                        w_mem_write = 1'b1;
                        w_mem_addr  = bus.req_addr;
                        if (bus.req_funct3[1:0] == 2'b10) begin
                            w_mem_size  = SIZE_WORD;
                            w_mem_wdata = bus.req_wdata;
                        end else begin
                            w_mem_size  = SIZE_BYTE;
                            w_mem_wdata = {24'b0, bus.req_wdata[7:0]};
                        end
                    end
                end
            end
            ST_RD: begin
                w_state    = ST_CAP;
                w_mem_read = 1'b0;
            end
            ST_CAP: begin
                w_state      = ST_RESP;
                w_resp_valid = 1'b1;
                w_resp_err   = 1'b0;
                w_resp_rdata = w_load_data;
            end
            ST_WR, ST_WR_HI: begin
                w_state      = ST_RESP;
                w_mem_write  = 1'b0;
                w_resp_valid = 1'b1;
                w_resp_err   = 1'b0;
                w_resp_rdata = 32'h0;
            end
            ST_WR_LO: begin
                // SH addresses are even, so addr+1 only sets bit 0.
                w_state     = ST_WR_HI;
                w_mem_size  = SIZE_BYTE;
                w_mem_addr  = {r_addr[ADDR_W-1:1], 1'b1};
                w_mem_wdata = {24'b0, r_wdata[15:8]};
            end
            ST_RESP: begin
                w_state      = ST_IDLE;
                w_resp_valid = 1'b0;
                w_resp_err   = 1'b0;
                w_resp_rdata = 32'h0;
            end
            default: begin
                w_state      = ST_IDLE;
                w_resp_valid = 1'b0;
                w_resp_err   = 1'b0;
                w_resp_rdata = 32'h0;
                w_mem_read   = 1'b0;
                w_mem_write  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_size   <= 3'b000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
        end else begin
            r_state      <= w_state;
            r_funct3     <= w_funct3;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_resp_valid <= w_resp_valid;
            r_resp_rdata <= w_resp_rdata;
            r_resp_err   <= w_resp_err;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_mem_size   <= w_mem_size;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_size   = r_mem_size;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_WORDS = 8001;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // RAM model driven by the DUT's memory port
    logic [31:0] ram [MEM_WORDS];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int bus_viol = 0;
    logic [31:0] wlog_addr [$];
    logic [7:0]  wlog_data [$];

    always @(posedge clk) begin
        if (bus.mem_read) begin
            rd_cnt <= rd_cnt + 1;
            bus.mem_rdata <= (bus.mem_addr[31:2] < MEM_WORDS) ? ram[bus.mem_addr[31:2]] : 32'h0;
        end
        if (bus.mem_write) begin
            wr_cnt <= wr_cnt + 1;
            if (bus.mem_addr[31:2] < MEM_WORDS) begin
                if (bus.mem_size == 3'b010) begin
                    ram[bus.mem_addr[31:2]] <= bus.mem_wdata;
                end else begin
                    wlog_addr.push_back(bus.mem_addr);
                    wlog_data.push_back(bus.mem_wdata[7:0]);
                    case (bus.mem_addr[1:0])
                        2'b00: ram[bus.mem_addr[31:2]][7:0]   <= bus.mem_wdata[7:0];
                        2'b01: ram[bus.mem_addr[31:2]][15:8]  <= bus.mem_wdata[7:0];
                        2'b10: ram[bus.mem_addr[31:2]][23:16] <= bus.mem_wdata[7:0];
                        default: ram[bus.mem_addr[31:2]][31:24] <= bus.mem_wdata[7:0];
                    endcase
                end
            end
        end
    end

    // Port rule monitor: never read+write together, never halfword size, reads are word size
    always @(negedge clk) begin
        if (resetn && ((bus.mem_read && bus.mem_write) ||
                       ((bus.mem_read || bus.mem_write) && bus.mem_size == 3'b001) ||
                       (bus.mem_read && bus.mem_size != 3'b010)))
            bus_viol <= bus_viol + 1;
    end

    // Reference model: byte-addressed view of memory plus the request rules
    logic [31:0] ref_mem [MEM_WORDS];

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ram[a / 4] = v;
        ref_mem[a / 4] = v;
    endtask

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 == 0 || f3 == 1 || f3 == 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!legal) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 2 && (a % 4 != 0)) return 1'b1;
        if (a / 4 >= MEM_WORDS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_lat(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (ref_err(we, f3, a)) return 1;
        if (!we) return 3;
        return (f3 == 1) ? 3 : 2;
    endfunction

    function automatic logic [31:0] ref_byte(input logic [31:0] a);
        return (ref_mem[a / 4] >> ((a % 4) * 8)) & 32'hFF;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        case (f3)
            3'd0: begin v = ref_byte(a); if (v >= 128) v = v + 32'hFFFFFF00; end
            3'd4: v = ref_byte(a);
            3'd1: begin v = ref_byte(a) + ref_byte(a + 1) * 256; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'd5: v = ref_byte(a) + ref_byte(a + 1) * 256;
            default: v = ref_mem[a / 4];
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ba;
            logic [31:0] lane;
            ba = a + i;
            lane = (ba % 4) * 8;
            ref_mem[ba / 4] = (ref_mem[ba / 4] & ~(32'hFF << lane)) | (((d >> (8 * i)) & 32'hFF) << lane);
        end
    endtask

    // One transaction: returns response fields, latency (-1 on timeout),
    // whether req_ready was seen high while busy, and whether outputs cleared after RESP.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdata, output logic err,
                          output int lat, output logic ready_leak, output logic cleared);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        lat = -1;
        rdata = 32'hx;
        err = 1'bx;
        ready_leak = 1'b0;
        cleared = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            if (bus.req_ready) ready_leak = 1'b1;
            if (bus.resp_valid) begin
                lat = n;
                rdata = bus.resp_rdata;
                err = bus.resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        cleared = !bus.resp_valid && bus.resp_rdata == 32'h0 && !bus.resp_err && bus.req_ready;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        checks++;
        if ({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got rv=%b re=%b mr=%b mw=%b want all 0",
                     bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write);
        end
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 ||
            bus.mem_size !== 3'b000) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h size=%b want all 0",
                     bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_size);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0};
        logic [31:0] adr [6] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100, 32'h100};
        logic [31:0] exp [6] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB,
                                 32'h8899AABB, 32'hFFFFFFBB};
        logic [31:0] r;
        logic e, lk, cl;
        int l;
        preload(32'h100, 32'h8899AABB);
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, f3s[i], adr[i], 32'h0, r, e, l, lk, cl);
            checks++;
            if (r !== exp[i] || e !== 1'b0 || l != 3 || !cl) begin
                errors++;
                $display("FAIL load_%0d f3=%0d addr=%h: got rdata=%h err=%b lat=%0d cleared=%b want rdata=%h err=0 lat=3 cleared=1",
                         i, f3s[i], adr[i], r, e, l, cl, exp[i]);
            end
        end
    endtask

    task automatic test_sh_split();
        logic [31:0] r;
        logic e, lk, cl;
        int l;
        preload(32'h104, 32'h0);
        wlog_addr.delete();
        wlog_data.delete();
        do_req(1'b1, 3'd1, 32'h106, 32'h00001234, r, e, l, lk, cl);
        ref_store(3'd1, 32'h106, 32'h00001234);
        checks++;
        if (e !== 1'b0 || l != 3 || r !== 32'h0) begin
            errors++;
            $display("FAIL sh_resp: got err=%b lat=%0d rdata=%h want err=0 lat=3 rdata=0", e, l, r);
        end
        checks++;
        if (wlog_addr.size() != 2 || wlog_addr[0] !== 32'h106 || wlog_data[0] !== 8'h34 ||
            wlog_addr[1] !== 32'h107 || wlog_data[1] !== 8'h12) begin
            errors++;
            $display("FAIL sh_bytes: got %0d byte writes want 0x106=34 then 0x107=12",
                     wlog_addr.size());
        end
        do_req(1'b0, 3'd2, 32'h104, 32'h0, r, e, l, lk, cl);
        checks++;
        if (r !== 32'h12340000 || e !== 1'b0) begin
            errors++;
            $display("FAIL sh_readback: got %h err=%b want 12340000 err=0", r, e);
        end
    endtask

    task automatic test_errors();
        logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [5] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] adr [5] = '{32'h102, 32'h101, MEM_WORDS * 4, 32'h100, 32'h100};
        logic [31:0] r;
        logic e, lk, cl;
        int l, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            do_req(wes[i], f3s[i], adr[i], 32'hCAFEF00D, r, e, l, lk, cl);
            checks++;
            if (e !== 1'b1 || l != 1 || r !== 32'h0 || !cl) begin
                errors++;
                $display("FAIL err_%0d we=%b f3=%0d addr=%h: got err=%b lat=%0d rdata=%h cleared=%b want err=1 lat=1 rdata=0 cleared=1",
                         i, wes[i], f3s[i], adr[i], e, l, r, cl);
            end
        end
        checks++;
        if (rd_cnt != rd0 || wr_cnt != wr0) begin
            errors++;
            $display("FAIL err_no_access: got %0d reads %0d writes want 0 0",
                     rd_cnt - rd0, wr_cnt - wr0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic e, lk1, lk2, cl;
        int l1, l2;
        do_req(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, r, e, l1, lk1, cl);
        ref_store(3'd2, 32'h200, 32'hDEADBEEF);
        do_req(1'b0, 3'd2, 32'h200, 32'h0, r, e, l2, lk2, cl);
        checks++;
        if (r !== 32'hDEADBEEF || e !== 1'b0 || l1 != 2 || l2 != 3) begin
            errors++;
            $display("FAIL b2b_data: got rdata=%h err=%b lat_sw=%0d lat_lw=%0d want deadbeef 0 2 3",
                     r, e, l1, l2);
        end
        checks++;
        if (lk1 || lk2) begin
            errors++;
            $display("FAIL b2b_ready: got ready high while busy (sw=%b lw=%b) want 0", lk1, lk2);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, d, r, exp_r;
        logic e, exp_e, lk, cl;
        int l, exp_l;
        for (int w = 'hC0; w < 'hD0; w++) preload(w * 4, $urandom);
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = MEM_WORDS * 4 + $urandom_range(0, 255);
            else a = 32'h300 + $urandom_range(0, 63);
            d = $urandom;
            exp_e = ref_err(we, f3, a);
            exp_l = ref_lat(we, f3, a);
            exp_r = (!exp_e && !we) ? ref_load(f3, a) : 32'h0;
            do_req(we, f3, a, d, r, e, l, lk, cl);
            if (!exp_e && we) ref_store(f3, a, d);
            checks++;
            if (r !== exp_r || e !== exp_e || l != exp_l || lk || !cl) begin
                errors++;
                $display("FAIL rand_%0d we=%b f3=%0d addr=%h: got rdata=%h err=%b lat=%0d leak=%b cleared=%b want rdata=%h err=%b lat=%0d leak=0 cleared=1",
                         i, we, f3, a, r, e, l, lk, cl, exp_r, exp_e, exp_l);
            end
        end
        checks++;
        if (bus_viol != 0) begin
            errors++;
            $display("FAIL mem_port_rules: got %0d violations want 0", bus_viol);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic e, lk, cl;
        int l;
        preload(32'h400, 32'h0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd1;
        bus.req_addr   = 32'h400;
        bus.req_wdata  = 32'h0000ABCD;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_write !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wrlo: got mem_write=%b ready=%b want 1 0", bus.mem_write, bus.req_ready);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.req_ready !== 1'b1 ||
            bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0 ||
            bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_size !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_async: got mw=%b mr=%b ready=%b rv=%b addr=%h wdata=%h size=%b want 0 0 1 0 0 0 0",
                     bus.mem_write, bus.mem_read, bus.req_ready, bus.resp_valid,
                     bus.mem_addr, bus.mem_wdata, bus.mem_size);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got ready=%b mw=%b want 1 0", bus.req_ready, bus.mem_write);
        end
        do_req(1'b0, 3'd2, 32'h400, 32'h0, r, e, l, lk, cl);
        checks++;
        if ((r !== 32'h0 && r !== 32'h000000CD) || e !== 1'b0 || l != 3) begin
            errors++;
            $display("FAIL rst_mid_recover: got rdata=%h err=%b lat=%0d want 0 or cd, 0, 3", r, e, l);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        for (int w = 0; w < MEM_WORDS; w++) begin
            ram[w] = 32'h0;
            ref_mem[w] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_loads();
        test_sh_split();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
